// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler
// Receive-side descrambler for a 32-bit XOR-scrambled word stream.
// The transmitter keystream is rebuilt with a 32-bit Galois LFSR that is
// advanced 32 steps per accepted word. The LFSR returns to SEED after the
// last word of every frame. One registered valid/ready output stage.
// Optional build: define XOR_STREAM_CHECKSUM_EN to add a per-frame XOR
// checksum of the plaintext (chk_valid / checksum ports).

module xor_stream_descrambler #(
   parameter logic [31:0] POLY = 32'h04C11DB7,
   parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seed_load,
   input  logic [31:0] seed_val,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic [15:0] word_count
`ifdef XOR_STREAM_CHECKSUM_EN
   ,
   output logic        chk_valid,
   output logic [31:0] checksum
`endif
);

   // 32 Galois steps unrolled into one combinational block per word.
   function automatic logic [31:0] f_advance(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < 32; i++) begin
         v = {v[30:0], 1'b0} ^ (v[31] ? POLY : 32'h0);
      end
      return v;
   endfunction

   logic [31:0] r_lfsr;
   logic        r_out_valid;
   logic [31:0] r_out_data;
   logic        r_out_last;
   logic [15:0] r_word_count;

   logic        w_in_ready;
   logic        w_accept;
   logic [31:0] w_plain;
   logic [31:0] w_next_key;

   // Ready whenever the output stage is empty or draining; a seed load
   // owns the LFSR for its cycle so no word may be taken then.
   always_comb begin
      w_in_ready = !seed_load && (!r_out_valid || out_ready);
      w_accept   = in_valid && w_in_ready;
      w_plain    = in_data ^ r_lfsr;
      w_next_key = f_advance(r_lfsr);
   end

   // Keystream state, output register and frame word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr       <= SEED;
         r_out_valid  <= 1'b0;
         r_out_data   <= 32'h0;
         r_out_last   <= 1'b0;
         r_word_count <= 16'h0;
      end else begin
         if (seed_load) begin
            r_lfsr <= seed_val;
         end else if (w_accept) begin
            r_lfsr <= in_last ? SEED : w_next_key;
         end

         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_plain;
            r_out_last  <= in_last;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_accept) begin
            if (in_last) begin
               r_word_count <= 16'h0;
            end else if (r_word_count != 16'hFFFF) begin
               r_word_count <= r_word_count + 16'd1;
            end
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_last   = r_out_last;
   assign word_count = r_word_count;

`ifdef XOR_STREAM_CHECKSUM_EN
   logic [31:0] r_acc;
   logic [31:0] r_checksum;
   logic        r_chk_valid;

   // Running XOR of the frame's plaintext; published on the last word so
   // chk_valid rises together with out_valid for that word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= 32'h0;
         r_checksum  <= 32'h0;
         r_chk_valid <= 1'b0;
      end else begin
         r_chk_valid <= 1'b0;
         if (w_accept) begin
            if (in_last) begin
               r_checksum  <= r_acc ^ w_plain;
               r_chk_valid <= 1'b1;
               r_acc       <= 32'h0;
            end else begin
               r_acc <= r_acc ^ w_plain;
            end
         end
      end
   end

   assign chk_valid = r_chk_valid;
   assign checksum  = r_checksum;
`endif

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Self-checking bench for xor_stream_descrambler: directed literal checks
// followed by a randomized run against a frame-level reference model.
module tb_xor_stream_descrambler;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [31:0] seed_val;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic [15:0] word_count;
`ifdef XOR_STREAM_CHECKSUM_EN
   logic        chk_valid;
   logic [31:0] checksum;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   xor_stream_descrambler #(.POLY(POLY), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n),
      .seed_load(seed_load), .seed_val(seed_val),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .word_count(word_count)
`ifdef XOR_STREAM_CHECKSUM_EN
      , .chk_valid(chk_valid), .checksum(checksum)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Key for word n of a frame started from seed s: the seed stepped 32*n times.
   function automatic logic [31:0] key_of(input logic [31:0] s, input int n);
      logic [31:0] v;
      v = s;
      for (int k = 0; k < 32 * n; k++) begin
         if (v[31]) v = (v << 1) ^ POLY;
         else       v = v << 1;
      end
      return v;
   endfunction

   task automatic send(input logic [31:0] d, input logic l);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // reference model state
   logic [31:0] m_seed;
   int          m_n;
   logic        m_ov;
   logic [31:0] m_od;
   logic        m_ol;
   logic [15:0] m_wc;
   logic [31:0] m_acc;
   logic [31:0] m_ck;
   logic        m_cv;

   initial begin
      logic        acc;
      logic [31:0] pt;
      rst_n = 1'b0; seed_load = 1'b0; seed_val = 32'h0;
      in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b1;

      // the model's keystream against hand-computed values
      chk("model_key_seed1_n1", key_of(32'h1, 1), 32'h04C11DB7);
      chk("model_key_n0", key_of(32'hA5A5A5A5, 0), 32'hA5A5A5A5);

      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_data",  out_data,           32'h0);
      chk("rst_out_last",  {31'h0, out_last},  32'h0);
      chk("rst_word_count",{16'h0, word_count},32'h0);
`ifdef XOR_STREAM_CHECKSUM_EN
      chk("rst_chk_valid", {31'h0, chk_valid}, 32'h0);
      chk("rst_checksum",  checksum,           32'h0);
`endif
      rst_n = 1'b1;

      send(32'h0, 1'b0);
      chk("first_word_key", out_data, 32'hFFFFFFFF);
      chk("first_word_valid", {31'h0, out_valid}, 32'h1);
      chk("first_word_count", {16'h0, word_count}, 32'h1);

      @(negedge clk);
      seed_load = 1'b1; seed_val = 32'h00000001;
      #1 chk("seed_load_blocks_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      seed_load = 1'b0;
      chk("seed_load_keeps_count", {16'h0, word_count}, 32'h1);
      send(32'h0, 1'b0);
      chk("seed1_word0", out_data, 32'h00000001);
      send(32'h0, 1'b0);
      chk("seed1_word1", out_data, 32'h04C11DB7);
      chk("seed1_count", {16'h0, word_count}, 32'h3);

      @(negedge clk);
      seed_load = 1'b1; seed_val = 32'h0;
      @(posedge clk); #1;
      seed_load = 1'b0;
      send(32'h12345678, 1'b0);
      chk("seed0_pass_a", out_data, 32'h12345678);

      // backpressure: hold the last word of the frame for three cycles
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
         chk("stall_out_data", out_data, 32'h12345678);
         chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("release_in_ready", {31'h0, in_ready}, 32'h1);
      @(posedge clk); #1;
      chk("seed0_pass_b", out_data, 32'hDEADBEEF);
      chk("seed0_last", {31'h0, out_last}, 32'h1);
      chk("frame_end_count", {16'h0, word_count}, 32'h0);
      @(negedge clk);
      in_data = 32'h0; in_last = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_seed_key", out_data, 32'hFFFFFFFF);
      chk("b2b_count", {16'h0, word_count}, 32'h1);
      chk("b2b_not_last", {31'h0, out_last}, 32'h0);

      send(32'h0, 1'b0);
      chk("pre_reset_count", {16'h0, word_count}, 32'h2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("midrst_count", {16'h0, word_count}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h0, 1'b0);
      chk("post_reset_key", out_data, 32'hFFFFFFFF);

`ifdef XOR_STREAM_CHECKSUM_EN
      @(negedge clk);
      seed_load = 1'b1; seed_val = 32'h0;
      @(posedge clk); #1;
      seed_load = 1'b0;
      send(32'h0000000F, 1'b0);
      send(32'h000000F0, 1'b1);
      chk("ck_pulse", {31'h0, chk_valid}, 32'h1);
      chk("ck_value", checksum, 32'h000000FF);
      @(posedge clk); #1;
      chk("ck_pulse_single", {31'h0, chk_valid}, 32'h0);
      chk("ck_hold", checksum, 32'h000000FF);
`endif

      // randomized run against the frame-level model
      do_reset();
      m_seed = SEED; m_n = 0; m_ov = 1'b0; m_od = 32'h0; m_ol = 1'b0; m_wc = 16'h0;
      m_acc = 32'h0; m_ck = 32'h0; m_cv = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         seed_load = ($urandom_range(0, 15) == 0);
         seed_val  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = $urandom;
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         acc = in_valid && !seed_load && (!m_ov || out_ready);
         #1 chk("rnd_in_ready", {31'h0, in_ready},
                {31'h0, !seed_load && (!m_ov || out_ready)});
         @(posedge clk);
         m_cv = 1'b0;
         if (seed_load) begin
            m_seed = seed_val; m_n = 0;
         end else if (acc) begin
            pt = in_data ^ key_of(m_seed, m_n);
            m_od = pt; m_ol = in_last; m_ov = 1'b1;
            if (in_last) begin
               m_ck = m_acc ^ pt; m_cv = 1'b1; m_acc = 32'h0;
               m_seed = SEED; m_n = 0; m_wc = 16'h0;
            end else begin
               m_acc = m_acc ^ pt;
               m_n++;
               if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            end
         end
         if (!acc && out_ready) m_ov = 1'b0;
         #1;
         chk("rnd_out_valid", {31'h0, out_valid}, {31'h0, m_ov});
         chk("rnd_out_data", out_data, m_od);
         chk("rnd_out_last", {31'h0, out_last}, {31'h0, m_ol});
         chk("rnd_word_count", {16'h0, word_count}, {16'h0, m_wc});
`ifdef XOR_STREAM_CHECKSUM_EN
         chk("rnd_chk_valid", {31'h0, chk_valid}, {31'h0, m_cv});
         chk("rnd_checksum", checksum, m_ck);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
